layer_fetch_sched: RTL and testbench

Time-multiplexed fetch scheduler and compositor for the sprite pipeline. Per logical 320x240 pixel (4 Clk cycles at 50 MHz), it sequences one shared index memory across four layers (attack, player, enemy, background) in priority order. It resolves the top non-transparent index, performs one shared palette lookup, and registers 24-bit RGB for the VGA outputs. It replaces per-layer palette copies and the combinational priority mux at the top level.

---
 rtl/boxhead_gfx_pkg.sv | 22 ++
 rtl/layer_prio_resolve.sv | 61 ++++++
 rtl/layer_fetch_sched.sv | 128 ++++++++++++
 tb/tb_layer_fetch_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boxhead_gfx_pkg.sv
// rtl/boxhead_gfx_pkg.sv - shared layer, index and latency definitions for the sprite pipeline
package boxhead_gfx_pkg;

    typedef enum logic [1:0] {
        ATTACK = 2'd0,
        PLAYER = 2'd1,
        ENEMY  = 2'd2,
        BKG    = 2'd3
    } layer_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } slot_state_e;

    localparam int NUM_LAYERS      = 4;
    localparam int TRANSPARENT_IDX = 0;
    localparam int FETCH_LAT       = 1;
    localparam int PAL_LAT         = 1;
    localparam int PIPE_LAT        = 8;

endpackage

// File: rtl/layer_prio_resolve.sv
// rtl/layer_prio_resolve.sv - per-pixel winner tracking, fed by the slot tag one cycle after issue
module layer_prio_resolve
    import boxhead_gfx_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tag_valid_i,
    input  logic [1:0]       tag_slot_i,
    input  logic             tag_issued_i,
    input  logic [IDX_W-1:0] rdata_i,
    output logic             found_o,
    output logic             done_o,
    output logic [IDX_W-1:0] win_idx_d_o,
    output logic [1:0]       win_layer_d_o
);

    logic             found_q, found_d, found_prev, hit, is_bkg;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [1:0]       win_layer_q, win_layer_d;

    // Slot 0 starts a fresh pixel, so the previous pixel's found flag is ignored there.
    always_comb begin
        is_bkg      = (tag_slot_i == 2'(BKG));
        found_prev  = (tag_slot_i == 2'(ATTACK)) ? 1'b0 : found_q;
        hit         = tag_valid_i && tag_issued_i && !found_prev &&
                      ((rdata_i != IDX_W'(TRANSPARENT_IDX)) || is_bkg);
        found_d     = found_q;
        win_idx_d   = win_idx_q;
        win_layer_d = win_layer_q;
        if (tag_valid_i) begin
            found_d = found_prev || hit;
            if (hit) begin
                win_idx_d   = rdata_i;
                win_layer_d = tag_slot_i;
            end else if (is_bkg && !found_prev) begin
                win_idx_d   = '0;
                win_layer_d = 2'(BKG);
                found_d     = 1'b1;
            end
        end
        found_o       = found_d;
        done_o        = tag_valid_i && is_bkg;
        win_idx_d_o   = win_idx_d;
        win_layer_d_o = win_layer_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            found_q     <= 1'b0;
            win_idx_q   <= '0;
            win_layer_q <= 2'd0;
        end else begin
            found_q     <= found_d;
            win_idx_q   <= win_idx_d;
            win_layer_q <= win_layer_d;
        end
    end

endmodule

// File: rtl/layer_fetch_sched.sv
// rtl/layer_fetch_sched.sv - four-slot shared index fetch, priority resolve and palette compositing
module layer_fetch_sched
    import boxhead_gfx_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int IDX_W   = 5,
    parameter int COLOR_W = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pixel_sync_i,
    input  logic [NUM_LAYERS-1:0]      layer_req_i,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr_i,
    output logic                       mem_en_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic [IDX_W-1:0]           mem_rdata_i,
    output logic [IDX_W-1:0]           pal_addr_o,
    input  logic [COLOR_W-1:0]         pal_rdata_i,
    output logic [COLOR_W-1:0]         rgb_o,
    output logic                       rgb_valid_o,
    output logic [1:0]                 win_layer_o,
    output logic                       sync_err_o
);

    slot_state_e                   state_q;
    logic [1:0]                    slot_q, next_slot;
    logic [NUM_LAYERS-1:0]         req_q;
    logic [NUM_LAYERS*ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]             mem_addr_q;
    logic                          tag_valid_q, tag_issued_q;
    logic [1:0]                    tag_slot_q;
    logic [IDX_W-1:0]              pal_addr_q;
    logic                          pv1_q, pv2_q;
    logic [1:0]                    pl1_q, pl2_q;
    logic [COLOR_W-1:0]            rgb_q;
    logic                          rgb_valid_q;
    logic [1:0]                    win_layer_q;
    logic                          sync_err_q;

    logic                          accept, en_base, found, done;
    logic [IDX_W-1:0]              win_idx_d;
    logic [1:0]                    win_layer_d;

    layer_prio_resolve #(.IDX_W(IDX_W)) u_resolve (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tag_valid_i   (tag_valid_q),
        .tag_slot_i    (tag_slot_q),
        .tag_issued_i  (tag_issued_q),
        .rdata_i       (mem_rdata_i),
        .found_o       (found),
        .done_o        (done),
        .win_idx_d_o   (win_idx_d),
        .win_layer_d_o (win_layer_d)
    );

    // The enable must see the previous slot's read data in the same cycle, so it
    // is the only output qualified combinationally; slot 0 never sees the old pixel.
    always_comb begin
        accept    = pixel_sync_i && ((state_q == S_IDLE) || (slot_q == 2'(BKG)));
        next_slot = slot_q + 2'd1;
        en_base   = (state_q == S_ISSUE) && ((slot_q == 2'(BKG)) || req_q[slot_q]);
        mem_en_o  = en_base && !((slot_q != 2'(ATTACK)) && found);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            slot_q       <= 2'd0;
            req_q        <= '0;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            tag_valid_q  <= 1'b0;
            tag_slot_q   <= 2'd0;
            tag_issued_q <= 1'b0;
            pal_addr_q   <= '0;
            pv1_q        <= 1'b0;
            pv2_q        <= 1'b0;
            pl1_q        <= 2'd0;
            pl2_q        <= 2'd0;
            rgb_q        <= '0;
            rgb_valid_q  <= 1'b0;
            win_layer_q  <= 2'd0;
            sync_err_q   <= 1'b0;
        end else begin
            tag_valid_q  <= (state_q == S_ISSUE);
            tag_slot_q   <= slot_q;
            tag_issued_q <= mem_en_o;
            if (pixel_sync_i && !accept) begin
                sync_err_q <= 1'b1;
            end
            if (accept) begin
                state_q    <= S_ISSUE;
                slot_q     <= 2'd0;
                req_q      <= layer_req_i;
                addr_q     <= layer_addr_i;
                mem_addr_q <= layer_addr_i[ADDR_W-1:0];
            end else if (state_q == S_ISSUE) begin
                if (slot_q == 2'(BKG)) begin
                    state_q <= S_IDLE;
                end else begin
                    slot_q     <= next_slot;
                    mem_addr_q <= addr_q[next_slot*ADDR_W +: ADDR_W];
                end
            end
            pv1_q <= done;
            if (done) begin
                pal_addr_q <= win_idx_d;
                pl1_q      <= win_layer_d;
            end
            pv2_q       <= pv1_q;
            pl2_q       <= pl1_q;
            rgb_valid_q <= pv2_q;
            if (pv2_q) begin
                rgb_q       <= pal_rdata_i;
                win_layer_q <= pl2_q;
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign pal_addr_o  = pal_addr_q;
    assign rgb_o       = rgb_q;
    assign rgb_valid_o = rgb_valid_q;
    assign win_layer_o = win_layer_q;
    assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_layer_fetch_sched.sv
// tb/tb_layer_fetch_sched.sv - directed and back-to-back pixel checks against a priority model
module tb_layer_fetch_sched;

    localparam int NCYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_sync = 1'b0;
    logic [3:0]  layer_req = 4'h0;
    logic [63:0] layer_addr = 64'h0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [4:0]  mem_rdata = 5'd0;
    logic [4:0]  pal_addr;
    logic [23:0] pal_rdata = 24'h0;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic [1:0]  win_layer;
    logic        sync_err;

    layer_fetch_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pixel_sync_i (pixel_sync),
        .layer_req_i  (layer_req),
        .layer_addr_i (layer_addr),
        .mem_en_o     (mem_en),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .pal_addr_o   (pal_addr),
        .pal_rdata_i  (pal_rdata),
        .rgb_o        (rgb),
        .rgb_valid_o  (rgb_valid),
        .win_layer_o  (win_layer),
        .sync_err_o   (sync_err)
    );

    always #5 clk = ~clk;

    logic [4:0]  idx_mem [0:65535];
    logic [23:0] pal [0:31];

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= idx_mem[mem_addr];
        pal_rdata <= pal[pal_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          exp_en  [0:NCYC-1];
    logic [15:0] exp_addr[0:NCYC-1];
    bit          exp_pv  [0:NCYC-1];
    logic [4:0]  exp_pal [0:NCYC-1];
    bit          exp_v   [0:NCYC-1];
    logic [23:0] exp_rgb [0:NCYC-1];
    logic [1:0]  exp_wl  [0:NCYC-1];
    int          err_cyc  = 1 << 30;
    int          last_acc = -100;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pixel model: walk layers in priority order; the first requested layer with a
    // non-zero index wins, background always wins if reached.
    task automatic send(input logic [3:0] req, input logic [63:0] addrs);
        int c;
        logic [15:0] a;
        logic [4:0]  widx;
        logic [1:0]  wl;
        c = cyc;
        pixel_sync = 1'b1;
        layer_req  = req;
        layer_addr = addrs;
        if (c >= last_acc + 4) begin
            last_acc = c;
            widx = 5'd0;
            wl   = 2'd3;
            for (int s = 0; s < 4; s++) begin
                a = addrs[s*16 +: 16];
                if (s == 3 || req[s]) begin
                    exp_en[c+1+s]   = 1'b1;
                    exp_addr[c+1+s] = a;
                    if (s == 3 || idx_mem[a] != 5'd0) begin
                        widx = idx_mem[a];
                        wl   = 2'(s);
                        break;
                    end
                end
            end
            exp_pv[c+6]  = 1'b1;
            exp_pal[c+6] = widx;
            exp_v[c+8]   = 1'b1;
            exp_rgb[c+8] = pal[widx];
            exp_wl[c+8]  = wl;
        end else if (c + 1 < err_cyc) begin
            err_cyc = c + 1;
        end
        @(negedge clk);
        pixel_sync = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cyc < NCYC - 16) begin
                if (rst) begin
                    chk("rst_mem_en", 32'(mem_en), 32'd0);
                    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                    chk("rst_pal_addr", 32'(pal_addr), 32'd0);
                    chk("rst_rgb", 32'(rgb), 32'd0);
                    chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
                    chk("rst_win_layer", 32'(win_layer), 32'd0);
                    chk("rst_sync_err", 32'(sync_err), 32'd0);
                end else begin
                    chk("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
                    if (exp_en[cyc]) chk("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
                    if (exp_pv[cyc]) chk("pal_addr", 32'(pal_addr), 32'(exp_pal[cyc]));
                    chk("rgb_valid", 32'(rgb_valid), 32'(exp_v[cyc]));
                    if (exp_v[cyc]) begin
                        chk("rgb", 32'(rgb), 32'(exp_rgb[cyc]));
                        chk("win_layer", 32'(win_layer), 32'(exp_wl[cyc]));
                    end
                    chk("sync_err", 32'(sync_err), 32'(cyc >= err_cyc));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 65536; i++) idx_mem[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        for (int i = 0; i < 32; i++) pal[i] = 24'($urandom);
        pal[0] = 24'h0A0B0C;
        pal[6] = 24'hC0FFEE;
        pal[7] = 24'h123456;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All layers requested, indices {0,7,3,9}: player wins.
        idx_mem[16'h0100] = 5'd0; idx_mem[16'h0101] = 5'd7;
        idx_mem[16'h0102] = 5'd3; idx_mem[16'h0103] = 5'd9;
        c0 = cyc;
        send(4'hF, {16'h0103, 16'h0102, 16'h0101, 16'h0100});
        at(c0 + 1); chk("t1_en_c1", 32'(mem_en), 32'd1);
        at(c0 + 2); chk("t1_en_c2", 32'(mem_en), 32'd1);
        at(c0 + 3); chk("t1_en_c3", 32'(mem_en), 32'd0);
        at(c0 + 4); chk("t1_en_c4", 32'(mem_en), 32'd0);
        at(c0 + 6); chk("t1_pal_addr", 32'(pal_addr), 32'd7);
        at(c0 + 8);
        chk("t1_valid", 32'(rgb_valid), 32'd1);
        chk("t1_layer", 32'(win_layer), 32'd1);
        chk("t1_rgb", 32'(rgb), 32'h123456);
        at(c0 + 10);

        // Background only with index 0: still opaque.
        idx_mem[16'h0200] = 5'd4; idx_mem[16'h0201] = 5'd4;
        idx_mem[16'h0202] = 5'd4; idx_mem[16'h0203] = 5'd0;
        c0 = cyc;
        send(4'b1000, {16'h0203, 16'h0202, 16'h0201, 16'h0200});
        at(c0 + 3); chk("t2_en_c3", 32'(mem_en), 32'd0);
        at(c0 + 4); chk("t2_en_c4", 32'(mem_en), 32'd1);
        at(c0 + 6); chk("t2_pal_addr", 32'(pal_addr), 32'd0);
        at(c0 + 8);
        chk("t2_valid", 32'(rgb_valid), 32'd1);
        chk("t2_layer", 32'(win_layer), 32'd3);
        chk("t2_rgb", 32'(rgb), 32'h0A0B0C);
        at(c0 + 10);

        // Attack index 5 not requested: player transparent, enemy (6) wins.
        idx_mem[16'h0300] = 5'd5; idx_mem[16'h0301] = 5'd0;
        idx_mem[16'h0302] = 5'd6; idx_mem[16'h0303] = 5'd2;
        c0 = cyc;
        send(4'b1110, {16'h0303, 16'h0302, 16'h0301, 16'h0300});
        at(c0 + 1); chk("t5_en_c1", 32'(mem_en), 32'd0);
        at(c0 + 4); chk("t5_en_c4", 32'(mem_en), 32'd0);
        at(c0 + 8);
        chk("t5_layer", 32'(win_layer), 32'd2);
        chk("t5_rgb", 32'(rgb), 32'hC0FFEE);
        at(c0 + 10);

        // Back-to-back pixels every 4 cycles with random requests and addresses.
        for (int p = 0; p < 100; p++) begin
            send(4'($urandom), {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        // Reset in cycle 3, released in cycle 5: pixel discarded.
        c0 = cyc;
        send(4'hF, {16'h0103, 16'h0102, 16'h0101, 16'h0100});
        at(c0 + 3);
        rst = 1'b1;
        for (int i = c0 + 3; i < c0 + 12; i++) begin
            exp_en[i] = 1'b0; exp_pv[i] = 1'b0; exp_v[i] = 1'b0;
        end
        last_acc = -100;
        at(c0 + 5);
        rst = 1'b0;
        at(c0 + 8); chk("rst_no_valid", 32'(rgb_valid), 32'd0);
        at(c0 + 10);
        c0 = cyc;
        send(4'hF, {16'h0103, 16'h0102, 16'h0101, 16'h0100});
        at(c0 + 7); chk("post_rst_c7", 32'(rgb_valid), 32'd0);
        at(c0 + 8);
        chk("post_rst_valid", 32'(rgb_valid), 32'd1);
        chk("post_rst_rgb", 32'(rgb), 32'h123456);
        at(c0 + 10);

        // Second pulse two cycles in is ignored and flagged.
        c0 = cyc;
        send(4'b1110, {16'h0303, 16'h0302, 16'h0301, 16'h0300});
        at(c0 + 2);
        send(4'hF, {16'h0103, 16'h0102, 16'h0101, 16'h0100});
        at(c0 + 3); chk("err_set", 32'(sync_err), 32'd1);
        at(c0 + 8);
        chk("err_valid", 32'(rgb_valid), 32'd1);
        chk("err_layer", 32'(win_layer), 32'd2);
        chk("err_rgb", 32'(rgb), 32'hC0FFEE);
        at(c0 + 12);
        chk("err_sticky", 32'(sync_err), 32'd1);
        chk("err_no_second", 32'(rgb_valid), 32'd0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
